// File: rtl/lstm_pkg.sv
// Shared LSTM activation types and constants. The default activation latency lives
// here so that the arbiter and the sigmoid/tanh units are always built with the same value.
package lstm_pkg;

  localparam int NUM_GATES           = 4;
  localparam int GATE_ID_W           = 2;
  localparam int Q88_W               = 16;
  localparam int ACT_LATENCY_DEFAULT = 5;

  localparam logic [GATE_ID_W-1:0] GATE_I = 2'd0;
  localparam logic [GATE_ID_W-1:0] GATE_F = 2'd1;
  localparam logic [GATE_ID_W-1:0] GATE_O = 2'd2;
  localparam logic [GATE_ID_W-1:0] GATE_G = 2'd3;

  typedef enum logic {
    ACT_SIGMOID = 1'b0,
    ACT_TANH    = 1'b1
  } act_func_t;

  typedef struct packed {
    logic                 valid;
    logic [GATE_ID_W-1:0] id;
    act_func_t            func;
    logic [Q88_W-1:0]     data;
  } act_packet_t;

endpackage

// File: rtl/lstm_act_arbiter_if.sv
// Bundle between the LSTM gate requesters, the shared activation unit and the arbiter.
// slave = the arbiter's view; master = the requester/activation-unit side.
interface lstm_act_arbiter_if
  import lstm_pkg::*;
#(
  parameter int NUM_REQ = NUM_GATES,
  parameter int DATA_W  = Q88_W
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_func;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           act_in_valid;
  logic [DATA_W-1:0]              act_in_data;
  logic                           act_in_func;
  logic [DATA_W-1:0]              act_out_data;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [DATA_W-1:0]              resp_data;
  logic                           busy;

  modport slave (
    input  req_valid, req_data, req_func, act_out_data,
    output req_ready, act_in_valid, act_in_data, act_in_func, resp_valid, resp_data, busy
  );

  modport master (
    output req_valid, req_data, req_func, act_out_data,
    input  req_ready, act_in_valid, act_in_data, act_in_func, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward with wrap,
// and the pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            accept,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);
  logic [ID_W-1:0] ptr_reg;
  logic [ID_W-1:0] ptr_next;
  logic [N-1:0]    upper_mask;
  logic [N-1:0]    upper_req;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (ID_W'(gi) >= ptr_reg);
    end
  endgenerate

  assign upper_req = req & upper_mask;

  // Lowest set bit at/above the pointer wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    if (|upper_req) begin
      grant = upper_req & (~upper_req + N'(1));
    end else begin
      grant = req & (~req + N'(1));
    end
  end

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    if (grant_id == ID_W'(N - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_id + ID_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (accept) begin
      ptr_reg <= ptr_next;
    end
  end
endmodule

// File: rtl/lstm_act_arbiter.sv
// Shares one fixed-latency activation unit among the LSTM gate requesters; a shadow pipe
// routes each result back to its issuer. Define LSTM_ACT_PERF_EN for grant/conflict counters.
module lstm_act_arbiter
  import lstm_pkg::*;
#(
  parameter int NUM_REQ     = NUM_GATES,
  parameter int DATA_W      = Q88_W,
  parameter int ACT_LATENCY = ACT_LATENCY_DEFAULT,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input logic               clock,
  input logic               reset,
  lstm_act_arbiter_if.slave bus
`ifdef LSTM_ACT_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0] perf_grants,
  output logic [31:0]              perf_conflicts
`endif
);
  logic [NUM_REQ-1:0]                 grant;
  logic [ID_W-1:0]                    grant_id;
  logic                               handshake;
  act_packet_t                        issue_reg;
  act_packet_t                        issue_next;
  logic [ACT_LATENCY-1:0]             shadow_valid_reg;
  logic [ACT_LATENCY-1:0]             shadow_valid_next;
  logic [ACT_LATENCY-1:0][ID_W-1:0]   shadow_id_reg;
  logic [ACT_LATENCY-1:0][ID_W-1:0]   shadow_id_next;
  logic [NUM_REQ-1:0]                 resp_valid_reg;
  logic [NUM_REQ-1:0]                 resp_valid_next;
  logic [DATA_W-1:0]                  resp_data_reg;
  logic [DATA_W-1:0]                  resp_data_next;

  genvar gi;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_arbiter (
    .clock    (clock),
    .reset    (reset),
    .req      (bus.req_valid),
    .accept   (handshake),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.req_ready = grant;
  assign handshake     = |(bus.req_valid & grant);

  // Operand and function hold their last values when nothing is issued.
  always_comb begin
    issue_next       = issue_reg;
    issue_next.valid = handshake;
    if (handshake) begin
      issue_next.id   = GATE_ID_W'(grant_id);
      issue_next.func = act_func_t'(bus.req_func[grant_id]);
      issue_next.data = Q88_W'(bus.req_data[grant_id]);
    end
  end

  // Shadow pipe runs in lockstep with the unit so its last stage lines up with act_out_data.
  generate
    for (gi = 0; gi < ACT_LATENCY; gi++) begin : g_shadow
      if (gi == 0) begin : g_head
        assign shadow_valid_next[gi] = issue_reg.valid;
        assign shadow_id_next[gi]    = ID_W'(issue_reg.id);
      end else begin : g_tail
        assign shadow_valid_next[gi] = shadow_valid_reg[gi-1];
        assign shadow_id_next[gi]    = shadow_id_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    resp_valid_next = '0;
    resp_data_next  = resp_data_reg;
    if (shadow_valid_reg[ACT_LATENCY-1]) begin
      resp_valid_next = NUM_REQ'(1) << shadow_id_reg[ACT_LATENCY-1];
      resp_data_next  = bus.act_out_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_reg        <= '0;
      shadow_valid_reg <= '0;
      shadow_id_reg    <= '0;
      resp_valid_reg   <= '0;
      resp_data_reg    <= '0;
    end else begin
      issue_reg        <= issue_next;
      shadow_valid_reg <= shadow_valid_next;
      shadow_id_reg    <= shadow_id_next;
      resp_valid_reg   <= resp_valid_next;
      resp_data_reg    <= resp_data_next;
    end
  end

  assign bus.act_in_valid = issue_reg.valid;
  assign bus.act_in_data  = DATA_W'(issue_reg.data);
  assign bus.act_in_func  = issue_reg.func;
  assign bus.resp_valid   = resp_valid_reg;
  assign bus.resp_data    = resp_data_reg;
  assign bus.busy         = issue_reg.valid | (|shadow_valid_reg);

`ifdef LSTM_ACT_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_grants_reg;
  logic [NUM_REQ-1:0][31:0] perf_grants_next;
  logic [31:0]              perf_conflicts_reg;
  logic [31:0]              perf_conflicts_next;
  logic                     multi_valid;

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi_valid = |(bus.req_valid & (bus.req_valid - NUM_REQ'(1)));

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
      assign perf_grants_next[gi] = (grant[gi] && !(&perf_grants_reg[gi]))
                                    ? perf_grants_reg[gi] + 32'd1 : perf_grants_reg[gi];
    end
  endgenerate

  assign perf_conflicts_next = (multi_valid && !(&perf_conflicts_reg))
                               ? perf_conflicts_reg + 32'd1 : perf_conflicts_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grants_reg    <= '0;
      perf_conflicts_reg <= '0;
    end else begin
      perf_grants_reg    <= perf_grants_next;
      perf_conflicts_reg <= perf_conflicts_next;
    end
  end

  assign perf_grants    = perf_grants_reg;
  assign perf_conflicts = perf_conflicts_reg;
`endif
endmodule

// File: tb/tb_lstm_act_arbiter.sv
// Randomised scoreboard bench for lstm_act_arbiter: a reference arbiter/unit model predicts
// grants, issues and responses; a monitor compares them as the DUT presents outputs.
module tb_lstm_act_arbiter;
  import lstm_pkg::*;

  parameter int LAT = ACT_LATENCY_DEFAULT;
  localparam int N  = NUM_GATES;
  localparam int DW = Q88_W;

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
    logic          func;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cycle = 0;
  int   vectors = 0;
  int   miscompares = 0;

  exp_t          issue_q[$];
  exp_t          resp_q[$];
  logic          pend   [N];
  logic [DW-1:0] pdata  [N];
  logic          pfunc  [N];
  int            model_ptr = 0;
  int            model_grants [N];
  int            model_conflicts = 0;
  logic [DW-1:0] unit_pipe [LAT];

  lstm_act_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

`ifdef LSTM_ACT_PERF_EN
  logic [N-1:0][31:0] perf_grants;
  logic [31:0]        perf_conflicts;
`endif

  lstm_act_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .ACT_LATENCY (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef LSTM_ACT_PERF_EN
    ,
    .perf_grants    (perf_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Q8.8 stand-in activation: sigmoid ~ 0.5 + x/4 clamped to [0,1], tanh ~ x clamped to [-1,1].
  function automatic logic [DW-1:0] act_model(input logic [DW-1:0] x, input logic f);
    int v;
    v = int'($signed(x));
    if (f) begin
      v = (v > 256) ? 256 : ((v < -256) ? -256 : v);
    end else begin
      v = (v >>> 2) + 128;
      v = (v < 0) ? 0 : ((v > 256) ? 256 : v);
    end
    return DW'(v);
  endfunction

  // Activation unit model: ACT_LATENCY registers, reset by the same signal as the arbiter.
  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) unit_pipe[k] <= '0;
    end else begin
      unit_pipe[0] <= act_model(bus.act_in_data, bus.act_in_func);
      for (int k = 1; k < LAT; k++) unit_pipe[k] <= unit_pipe[k-1];
    end
  end
  assign bus.act_out_data = unit_pipe[LAT-1];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, got, exp);
    end
  endtask

  // One requester cycle: drive pending requests, predict the round-robin winner, queue expectations.
  task automatic step();
    int            g;
    int            nvalid;
    logic [N-1:0]  exp_ready;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = pend[i];
      bus.req_data[i]  = pdata[i];
      bus.req_func[i]  = pfunc[i];
    end
    #1;
    g = -1;
    nvalid = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (model_ptr + k) % N;
      if (pend[idx]) nvalid++;
      if (pend[idx] && g < 0) g = idx;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    if (nvalid >= 2) model_conflicts++;
    if (g >= 0) begin
      issue_q.push_back('{cycle + 1, g, pdata[g], pfunc[g]});
      resp_q.push_back('{cycle + LAT + 2, g, act_model(pdata[g], pfunc[g]), pfunc[g]});
      model_grants[g]++;
      pend[g]   = 1'b0;
      model_ptr = (g + 1) % N;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b1;
    bus.req_valid = '0;
    @(posedge clock);
    #1;
    issue_q.delete();
    resp_q.delete();
    model_ptr       = 0;
    model_conflicts = 0;
    for (int i = 0; i < N; i++) begin
      pend[i]         = 1'b0;
      model_grants[i] = 0;
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

`ifdef LSTM_ACT_PERF_EN
  task automatic check_perf();
    for (int i = 0; i < N; i++) check("perf_grants", perf_grants[i], 32'(model_grants[i]));
    check("perf_conflicts", perf_conflicts, 32'(model_conflicts));
  endtask
`endif

  // Monitor: compare issue, response and busy against the scoreboard every cycle.
  initial begin : monitor
    logic         exp_v;
    logic [N-1:0] exp_rv;
    logic         exp_busy;
    forever begin
      @(negedge clock);
      exp_v = (issue_q.size() > 0) && (issue_q[0].due == cycle);
      check("act_in_valid", 32'(bus.act_in_valid), 32'(exp_v));
      if (exp_v) begin
        check("act_in_data", 32'(bus.act_in_data), 32'(issue_q[0].data));
        check("act_in_func", 32'(bus.act_in_func), 32'(issue_q[0].func));
        void'(issue_q.pop_front());
      end
      exp_rv = '0;
      if ((resp_q.size() > 0) && (resp_q[0].due == cycle)) exp_rv[resp_q[0].id] = 1'b1;
      check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      if (exp_rv != '0) begin
        check("resp_data", 32'(bus.resp_data), 32'(resp_q[0].data));
        void'(resp_q.pop_front());
      end
      exp_busy = (resp_q.size() > 0) && ((resp_q[0].due - LAT - 1) <= cycle);
      check("busy", 32'(bus.busy), 32'(exp_busy));
    end
  end

  initial begin : stimulus
    int cnt0;
    int cnt3;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_func  = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pdata[i] = '0; pfunc[i] = 1'b0; model_grants[i] = 0;
    end

    do_reset();
    check("rst_act_in_data", 32'(bus.act_in_data), 32'd0);
    check("rst_act_in_func", 32'(bus.act_in_func), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);

    // Single request from the output gate.
    pend[GATE_O]  = 1'b1;
    pdata[GATE_O] = 16'h0100;
    pfunc[GATE_O] = ACT_SIGMOID;
    step();
    repeat (LAT + 3) step();

    // All four gates at pointer 0.
    do_reset();
    pend[GATE_I] = 1'b1; pdata[GATE_I] = 16'h0010; pfunc[GATE_I] = ACT_SIGMOID;
    pend[GATE_F] = 1'b1; pdata[GATE_F] = 16'h0020; pfunc[GATE_F] = ACT_SIGMOID;
    pend[GATE_O] = 1'b1; pdata[GATE_O] = 16'h0030; pfunc[GATE_O] = ACT_SIGMOID;
    pend[GATE_G] = 1'b1; pdata[GATE_G] = 16'h0040; pfunc[GATE_G] = ACT_TANH;
    repeat (4) step();
    repeat (LAT + 3) step();
`ifdef LSTM_ACT_PERF_EN
    check_perf();
`endif

    // Fairness between requesters 0 and 3 held valid.
    cnt0 = 0;
    cnt3 = 0;
    repeat (10) begin
      if (!pend[0]) begin pend[0] = 1'b1; pdata[0] = DW'($urandom); pfunc[0] = 1'($urandom_range(0, 1)); end
      if (!pend[3]) begin pend[3] = 1'b1; pdata[3] = DW'($urandom); pfunc[3] = 1'($urandom_range(0, 1)); end
      step();
      cnt0 += int'(bus.req_ready[0]);
      cnt3 += int'(bus.req_ready[3]);
    end
    check("fair_grants_0", 32'(cnt0), 32'd5);
    check("fair_grants_3", 32'(cnt3), 32'd5);
    repeat (LAT + 4) step();

    // Mid-operation reset with three operations in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b1; pdata[i] = DW'($urandom); pfunc[i] = 1'($urandom_range(0, 1));
    end
    repeat (4) step();
    do_reset();
    check("rst_busy", 32'(bus.busy), 32'd0);
    repeat (LAT + 4) step();
    pend[1] = 1'b1; pdata[1] = 16'h0200; pfunc[1] = ACT_TANH;
    pend[3] = 1'b1; pdata[3] = 16'hff00; pfunc[3] = ACT_SIGMOID;
    repeat (LAT + 5) step();

    // Random traffic.
    repeat (300) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]  = 1'b1;
          pdata[i] = DW'($urandom);
          pfunc[i] = 1'($urandom_range(0, 1));
        end
      end
      step();
    end
    repeat (N + LAT + 4) step();
`ifdef LSTM_ACT_PERF_EN
    check_perf();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
